// File: rtl/team_06_vox_ctrl_pkg.sv
// Shared types and helpers for the voice talk/listen controller.
// Effect indices are the values carried on current_effect.
package team_06_pkg;

  typedef enum logic [1:0] {LIST, TALK, HANG} vox_state_t;

  localparam int EFF_NORMAL  = 0;
  localparam int EFF_ECHO    = 1;
  localparam int EFF_TREMOLO = 2;
  localparam int EFF_REVERB  = 3;
  localparam int EFF_SOFT    = 4;

  // Distance of an offset-binary sample from mid-scale.
  function automatic logic [31:0] aud_mag(input logic [31:0] sample, input int width);
    logic [31:0] mid;
    mid = 32'd1 << (width - 1);
    return (sample >= mid) ? (sample - mid) : (mid - sample);
  endfunction

endpackage

// File: rtl/team_06_vox_ctrl_if.sv
// Audio, threshold, button and status signals of the voice controller.
// The master side drives inputs; the controller is the slave.
interface team_06_vox_ctrl_if #(
    parameter int AUD_W = 8,
    parameter int EFF_W = 3
);
    logic [AUD_W-1:0] mic_aud;
    logic [AUD_W-1:0] spk_aud;
    logic [AUD_W-2:0] threshold;
    logic             ptt_en;
    logic             ng_btn;
    logic             mute_btn;
    logic             eff_next_btn;
    logic             eff_prev_btn;
    logic             talk;
    logic             hang_active;
    logic             vol_en;
    logic             effect_en;
    logic             mute_tog;
    logic             ng_on;
    logic [EFF_W-1:0] current_effect;

    modport master (
        output mic_aud, spk_aud, threshold, ptt_en,
               ng_btn, mute_btn, eff_next_btn, eff_prev_btn,
        input  talk, hang_active, vol_en, effect_en, mute_tog, ng_on, current_effect
    );

    modport slave (
        input  mic_aud, spk_aud, threshold, ptt_en,
               ng_btn, mute_btn, eff_next_btn, eff_prev_btn,
        output talk, hang_active, vol_en, effect_en, mute_tog, ng_on, current_effect
    );
endinterface

// File: rtl/team_06_vox_ctrl_btn_edge.sv
// Raw button synchroniser with a registered one-cycle rising-edge pulse.
// A level first sampled at edge k pulses rise after edge k+2.
module team_06_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);
    logic s1, s2, prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            prev <= s2;
            rise <= s2 & ~prev;
        end
    end
endmodule

// File: rtl/team_06_vox_ctrl.sv
// Talk/listen arbiter: push-to-talk, noise gate with hang time, speaker
// priority, plus mute / noise-gate / effect-select toggles.
module team_06_vox_ctrl
    import team_06_pkg::*;
#(
    parameter int AUD_W       = 8,
    parameter int NUM_EFFECTS = 5,
    parameter int HANG_CYCLES = 1048576,
    parameter int EFF_W       = $clog2(NUM_EFFECTS)
) (
    input  logic             clk,
    input  logic             rst,
    team_06_vox_ctrl_if.slave bus
);
    localparam logic [AUD_W-1:0] MID      = {1'b1, {(AUD_W-1){1'b0}}};
    localparam int               CNT_W    = $clog2(HANG_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HANG_CYCLES - 1);
    localparam logic [EFF_W-1:0] EFF_MAX  = EFF_W'(NUM_EFFECTS - 1);

    logic [AUD_W-1:0] mag;
    logic             loud, spk_active;
    logic [3:0]       rise;
    vox_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             ng_on, mute_tog;
    logic [EFF_W-1:0] eff;

    assign mag        = AUD_W'(aud_mag(32'(bus.mic_aud), AUD_W));
    assign loud       = (mag >= {1'b0, bus.threshold});
    assign spk_active = (bus.spk_aud != MID);

    // rise[0]=noise gate, [1]=mute, [2]=effect next, [3]=effect prev
    team_06_btn_edge u_btn [3:0] (
        .clk  (clk),
        .rst  (rst),
        .btn  ({bus.eff_prev_btn, bus.eff_next_btn, bus.mute_btn, bus.ng_btn}),
        .rise (rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ng_on    <= 1'b0;
            mute_tog <= 1'b0;
            eff      <= EFF_W'(EFF_NORMAL);
        end else begin
            // Far-end speech forces the gate off, even over a button press.
            if (spk_active)   ng_on <= 1'b0;
            else if (rise[0]) ng_on <= ~ng_on;
            if (rise[1]) mute_tog <= ~mute_tog;
            if (rise[2] && !rise[3])
                eff <= (eff == EFF_MAX) ? '0 : eff + 1'b1;
            else if (rise[3] && !rise[2])
                eff <= (eff == '0) ? EFF_MAX : eff - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LIST;
            cnt   <= '0;
        end else begin
            cnt <= '0;
            case (state)
                LIST: begin
                    if (!spk_active && (bus.ptt_en || (ng_on && loud))) state <= TALK;
                end
                TALK: begin
                    if (spk_active)                        state <= LIST;
                    else if (bus.ptt_en || (ng_on && loud)) state <= TALK;
                    else if (ng_on)                        state <= HANG;
                    else                                   state <= LIST;
                end
                HANG: begin
                    if (spk_active || !ng_on)       state <= LIST;
                    else if (bus.ptt_en || loud)    state <= TALK;
                    else if (cnt == CNT_LAST)       state <= LIST;
                    else                            cnt   <= cnt + 1'b1;
                end
                default: state <= LIST;
            endcase
        end
    end

    assign bus.talk           = (state != LIST);
    assign bus.hang_active    = (state == HANG);
    assign bus.effect_en      = (state != LIST) & ~rst;
    assign bus.vol_en         = (state == LIST) & ~mute_tog & ~rst;
    assign bus.mute_tog       = mute_tog;
    assign bus.ng_on          = ng_on;
    assign bus.current_effect = eff;
endmodule

// File: tb/tb_team_06_vox_ctrl.sv
// Scoreboard bench for team_06_vox_ctrl: directed scenarios then random
// stimulus, each cycle predicted by a behavioural model and checked later.
module tb_team_06_vox_ctrl;
    localparam int HANG = 8;

    typedef struct packed {
        logic       talk, hang, vol, effen, mute, ng;
        logic [2:0] eff;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    team_06_vox_ctrl_if #(.AUD_W(8), .EFF_W(3)) bus ();

    team_06_vox_ctrl #(.AUD_W(8), .NUM_EFFECTS(5), .HANG_CYCLES(HANG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // stimulus variables, applied at the falling edge
    logic [7:0] mic = 8'd128, spk = 8'd128;
    logic [6:0] thr = 7'd64;
    logic       ptt = 0, b_ng = 0, b_mute = 0, b_next = 0, b_prev = 0, r_in = 1;

    // model state: 0=listen 1=talk 2=hang
    int         m_st, m_left, m_eff;
    bit         m_ng, m_mute;
    bit [3:0]   hist [4];
    exp_t       q[$];
    int         n_chk = 0, n_pass = 0;

    task automatic step();
        bit   rs [4];
        bit   btn [4];
        int   mag;
        bit   loud, spk_act;
        exp_t e;
        btn = '{b_ng, b_mute, b_next, b_prev};
        if (r_in) begin
            m_st = 0; m_left = 0; m_eff = 0; m_ng = 0; m_mute = 0;
            for (int b = 0; b < 4; b++) hist[b] = '0;
        end else begin
            // a press sampled 3 edges ago, absent 4 edges ago, acts now
            for (int b = 0; b < 4; b++) rs[b] = hist[b][2] & ~hist[b][3];
            mag     = (int'(mic) >= 128) ? int'(mic) - 128 : 128 - int'(mic);
            loud    = (mag >= int'(thr));
            spk_act = (spk != 8'd128);
            case (m_st)
                0: if (!spk_act && (ptt || (m_ng && loud))) m_st = 1;
                1: begin
                    if (spk_act)                   m_st = 0;
                    else if (ptt || (m_ng && loud)) m_st = 1;
                    else if (m_ng) begin m_st = 2; m_left = HANG; end
                    else                           m_st = 0;
                end
                default: begin
                    if (spk_act || !m_ng)  m_st = 0;
                    else if (ptt || loud)  m_st = 1;
                    else begin
                        m_left--;
                        if (m_left == 0) m_st = 0;
                    end
                end
            endcase
            if (spk_act)    m_ng = 0;
            else if (rs[0]) m_ng = !m_ng;
            if (rs[1]) m_mute = !m_mute;
            if (rs[2] && !rs[3])      m_eff = (m_eff + 1) % 5;
            else if (rs[3] && !rs[2]) m_eff = (m_eff + 4) % 5;
            for (int b = 0; b < 4; b++) hist[b] = {hist[b][2:0], btn[b]};
        end
        e.talk  = (m_st != 0);
        e.hang  = (m_st == 2);
        e.effen = (m_st != 0) && !r_in;
        e.vol   = (m_st == 0) && !m_mute && !r_in;
        e.mute  = m_mute;
        e.ng    = m_ng;
        e.eff   = 3'(m_eff);
        q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            rst = r_in;
            bus.mic_aud = mic; bus.spk_aud = spk; bus.threshold = thr;
            bus.ptt_en = ptt; bus.ng_btn = b_ng; bus.mute_btn = b_mute;
            bus.eff_next_btn = b_next; bus.eff_prev_btn = b_prev;
            step();
        end
    endtask

    initial begin
        bus.mic_aud = 8'd128; bus.spk_aud = 8'd128; bus.threshold = 7'd64;
        bus.ptt_en = 0; bus.ng_btn = 0; bus.mute_btn = 0;
        bus.eff_next_btn = 0; bus.eff_prev_btn = 0;
    end

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {bus.talk, bus.hang_active, bus.vol_en, bus.effect_en,
                     bus.mute_tog, bus.ng_on, bus.current_effect};
                n_chk++;
                if (a === e) n_pass++;
                else $display("FAIL scoreboard t=%0t talk/hang/vol/effen/mute/ng/eff got %b expected %b",
                              $time, a, e);
            end
        end
    end

    initial begin : driver
        int wait_cyc;
        // reset, then PTT versus speaker priority
        cyc(2); r_in = 0; cyc(2);
        ptt = 1; cyc(2); spk = 8'd140; cyc(2); spk = 8'd128; ptt = 0; cyc(2);
        // gate on, talk, hang expiry, hang interrupted at cycle 5, reset mid-hang
        b_ng = 1; cyc(1); b_ng = 0; cyc(4);
        mic = 8'd200; cyc(2); mic = 8'd130; cyc(12);
        mic = 8'd200; cyc(2); mic = 8'd130; cyc(5); mic = 8'd60; cyc(2);
        mic = 8'd130; cyc(3); r_in = 1; cyc(1); r_in = 0; cyc(2);
        // gate cleared by speaker, then loud mic must not talk
        b_ng = 1; cyc(1); b_ng = 0; cyc(4);
        spk = 8'd100; cyc(1); spk = 8'd128; mic = 8'd255; cyc(4); mic = 8'd128;
        // effect wrap both ways and simultaneous presses
        for (int i = 0; i < 5; i++) begin b_next = 1; cyc(1); b_next = 0; cyc(4); end
        b_prev = 1; cyc(1); b_prev = 0; cyc(4);
        b_next = 1; b_prev = 1; cyc(1); b_next = 0; b_prev = 0; cyc(4);
        // mute held long gives one toggle; second press restores
        b_mute = 1; cyc(10); b_mute = 0; cyc(4);
        b_mute = 1; cyc(2); b_mute = 0; cyc(5);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r_in = ($urandom_range(199) == 0);
            spk  = ($urandom_range(7) == 0) ? 8'($urandom) : 8'd128;
            mic  = 8'($urandom);
            if ($urandom_range(15) == 0) thr = 7'($urandom);
            if ($urandom_range(9) == 0) ptt = !ptt;
            if ($urandom_range(5) == 0) b_ng = !b_ng;
            if ($urandom_range(5) == 0) b_mute = !b_mute;
            if ($urandom_range(5) == 0) b_next = !b_next;
            if ($urandom_range(5) == 0) b_prev = !b_prev;
            cyc(1);
        end
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin @(posedge clk); wait_cyc++; end
        #2;
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expected responses left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
